// File: rtl/wrr_credit_scheduler.sv
// Weighted round-robin pop scheduler for four source FIFOs with per-queue downstream credit (stats via WRR_STATS_EN).
// Latency: pop is registered, one pop per cycle with no bubble on a queue switch; valid trails pop by one cycle.
// Backpressure: halt freezes the turn and zeroes pop; a queue with zero credit is never popped.
module wrr_credit_scheduler #(
    parameter int W0    = 4,
    parameter int W1    = 3,
    parameter int W2    = 2,
    parameter int W3    = 1,
    parameter int WW    = 3,
    parameter int CW    = 3,
    parameter int CINIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  empty,
    input  logic [3:0]  almost_empty,
    input  logic        halt,
    input  logic [3:0]  credit_return,
    output logic [3:0]  pop,
    output logic        valid,
    output logic [1:0]  grant_idx,
    output logic        busy
`ifdef WRR_STATS_EN
    ,
    input  logic [1:0]  stat_sel,
    output logic [15:0] stat_cnt
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [1:0]    ptr, ptr_nxt, win;
    logic [WW-1:0] burst, burst_nxt;
    logic [3:0]    pop_nxt, elig;
    logic          found;
    logic [CW-1:0] credit [4];

    function automatic logic [WW-1:0] wt(input logic [1:0] q);
        case (q)
            2'd0:    return WW'(W0);
            2'd1:    return WW'(W1);
            2'd2:    return WW'(W2);
            default: return WW'(W3);
        endcase
    endfunction

    // A queue whose last word is being popped right now must not be popped again.
    always_comb begin
        elig = '0;
        for (int q = 0; q < 4; q++) begin
            elig[q] = !empty[q] && (credit[q] != '0) && (wt(2'(q)) != '0)
                      && !(pop[q] && almost_empty[q]);
        end
    end

    // Search ptr+1, ptr+2, ptr+3, then ptr itself last.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int i = 1; i <= 4; i++) begin
            if (!found && elig[ptr + 2'(i)]) begin
                found = 1'b1;
                win   = ptr + 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        burst_nxt = burst;
        pop_nxt   = '0;
        if (!halt) begin
            if (state == SERVE && burst != '0 && elig[ptr]) begin
                pop_nxt   = 4'b0001 << ptr;
                burst_nxt = burst - WW'(1);
            end else if (found) begin
                pop_nxt   = 4'b0001 << win;
                ptr_nxt   = win;
                burst_nxt = wt(win) - WW'(1);
                state_nxt = SERVE;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            burst <= '0;
            pop   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            burst <= burst_nxt;
            pop   <= pop_nxt;
            valid <= |pop;
        end
    end

    // A pop and a return in the same cycle cancel; returns above CINIT are dropped.
    always_ff @(posedge clk) begin
        for (int q = 0; q < 4; q++) begin
            if (reset) begin
                credit[q] <= CW'(CINIT);
            end else if (pop_nxt[q] && !credit_return[q]) begin
                credit[q] <= credit[q] - CW'(1);
            end else if (!pop_nxt[q] && credit_return[q] && credit[q] != CW'(CINIT)) begin
                credit[q] <= credit[q] + CW'(1);
            end
        end
    end

    assign grant_idx = ptr;
    assign busy      = (state == SERVE);

`ifdef WRR_STATS_EN
    logic [15:0] stat_q [4];

    always_ff @(posedge clk) begin
        for (int q = 0; q < 4; q++) begin
            if (reset) begin
                stat_q[q] <= '0;
            end else if (pop[q] && stat_q[q] != 16'hFFFF) begin
                stat_q[q] <= stat_q[q] + 16'd1;
            end
        end
    end

    assign stat_cnt = stat_q[stat_sel];
`endif

endmodule

// File: tb/tb_wrr_credit_scheduler.sv
// Directed bench for wrr_credit_scheduler: FIFO occupancy model, credit echo or manual returns.
// Stats counters are checked only when WRR_STATS_EN is defined.
module tb_wrr_credit_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  empty, almost_empty, credit_return, pop, cr_man;
    logic        halt = 1'b0;
    logic        cr_echo = 1'b1;
    logic        valid, busy;
    logic [1:0]  grant_idx;
    int          occ [4];
    int          n_cmp = 0;
    int          n_bad = 0;
`ifdef WRR_STATS_EN
    logic [1:0]  stat_sel = 2'd0;
    logic [15:0] stat_cnt;
`endif

    logic [3:0] exp1 [10] = '{4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h1, 4'h1, 4'h1, 4'h1};
    logic [1:0] idx1 [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [3:0] exp2 [8]  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0};
    logic [3:0] exp5 [10] = '{4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0};
    logic [15:0] exps [4] = '{16'd40, 16'd30, 16'd20, 16'd10};

    always #5 clk = ~clk;

    always_comb begin
        empty        = '0;
        almost_empty = '0;
        for (int q = 0; q < 4; q++) begin
            empty[q]        = (occ[q] == 0);
            almost_empty[q] = (occ[q] <= 1);
        end
    end

    always_comb credit_return = cr_echo ? pop : cr_man;

    wrr_credit_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .halt          (halt),
        .credit_return (credit_return),
        .pop           (pop),
        .valid         (valid),
        .grant_idx     (grant_idx),
        .busy          (busy)
`ifdef WRR_STATS_EN
        ,
        .stat_sel      (stat_sel),
        .stat_cnt      (stat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; the FIFO model drains the word popped during the cycle just ended.
    task automatic step();
        logic [3:0] p;
        p = pop;
        @(posedge clk);
        #1;
        for (int q = 0; q < 4; q++) begin
            if (p[q] && occ[q] > 0) occ[q]--;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        halt    = 1'b0;
        cr_echo = 1'b1;
        cr_man  = '0;
        for (int q = 0; q < 4; q++) occ[q] = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        cr_man = '0;

        // Weighted bursts with ample credit: 1x3, 2x2, 3x1, 0x4 repeating, no bubbles.
        do_reset();
        for (int q = 0; q < 4; q++) occ[q] = 1000;
        check("rst_pop", pop, 0);
        check("rst_valid", valid, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_busy", busy, 0);
        step();
        for (int k = 0; k < 100; k++) begin
            check("t1_pop", pop, exp1[k % 10]);
            check("t1_valid", valid, (k > 0) ? 1 : 0);
            check("t1_grant", grant_idx, idx1[k % 10]);
            if (k == 99) halt = 1'b1;
            step();
        end
        check("t1_halt_pop", pop, 0);
        check("t1_last_valid", valid, 1);
`ifdef WRR_STATS_EN
        for (int q = 0; q < 4; q++) begin
            stat_sel = 2'(q);
            #1;
            check("t6_stat", stat_cnt, exps[q]);
        end
`endif

        // Single queue, depth 5: the last back-to-back pop is held off by almost_empty.
        do_reset();
        occ[2] = 5;
        step();
        for (int k = 0; k < 8; k++) begin
            check("t2_pop", pop, exp2[k]);
            if (k == 5) check("t2_busy_idle", busy, 0);
            step();
        end

        // No credit return: exactly CINIT pops, then one more per returned credit.
        do_reset();
        occ[0]  = 1000;
        cr_echo = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            check("t3_pop", pop, (k < 4) ? 1 : 0);
            step();
        end
        cr_man = 4'b0001;
        step();
        cr_man = '0;
        check("t3_pop_after_ret", pop, 0);
        step();
        check("t3_extra_pop", pop, 1);
        step();
        check("t3_no_more_a", pop, 0);
        step();
        check("t3_no_more_b", pop, 0);

        // Halt after the first q1 pop freezes the turn; the burst resumes, then q2.
        do_reset();
        occ[1] = 1000;
        occ[2] = 1000;
        step();
        check("t4_first", pop, 4'h2);
        halt = 1'b1;
        step();
        check("t4_halt_pop_a", pop, 0);
        check("t4_halt_grant", grant_idx, 1);
        check("t4_halt_busy", busy, 1);
        step();
        check("t4_halt_pop_b", pop, 0);
        check("t4_halt_valid", valid, 0);
        step();
        check("t4_halt_pop_c", pop, 0);
        halt = 1'b0;
        step();
        check("t4_resume_a", pop, 4'h2);
        step();
        check("t4_resume_b", pop, 4'h2);
        step();
        check("t4_next_q", pop, 4'h4);
        check("t4_next_grant", grant_idx, 2);

        // Reset mid-burst: outputs clear, credits refill, search restarts after ptr 0.
        do_reset();
        occ[0]  = 1000;
        cr_echo = 1'b0;
        step();
        check("t5_pre_a", pop, 4'h1);
        step();
        check("t5_pre_b", pop, 4'h1);
        reset  = 1'b1;
        occ[1] = 1000;
        step();
        check("t5_rst_pop", pop, 0);
        check("t5_rst_valid", valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_grant", grant_idx, 0);
        reset = 1'b0;
        step();
        for (int k = 0; k < 10; k++) begin
            check("t5_pop", pop, exp5[k]);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
